// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift, rotate, arithmetic shift, load and clear,
// with a saturating count of shift ops since the last parallel load.
module univ_shift_reg #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         sin_l,
    input  logic                         sin_r,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         drained
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_ASR  = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drained_q, drained_d;
    logic [CNT_W-1:0] cnt_inc;

    // Shift-type ops advance the count until the loaded word has fully left
    assign cnt_inc = (cnt_q < CNT_FULL) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], sin_l};
                    cnt_d = cnt_inc;
                end
                MODE_SHR: begin
                    q_d   = {sin_r, q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
                MODE_ROL: begin
                    q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    cnt_d = cnt_inc;
                end
                MODE_ROR: begin
                    q_d   = {q_q[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                MODE_CLR: begin
                    q_d   = '0;
                    cnt_d = CNT_FULL;
                end
                MODE_ASR: begin
                    q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
        drained_d = (cnt_d == CNT_FULL);
    end

    // Reset leaves the register looking empty until the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RST_VAL;
            cnt_q     <= CNT_FULL;
            drained_q <= 1'b1;
        end else begin
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            drained_q <= drained_d;
        end
    end

    assign q       = q_q;
    assign bit_cnt = cnt_q;
    assign drained = drained_q;
    assign sout_l  = q_q[WIDTH-1];
    assign sout_r  = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8), plus a second instance with RST_VAL=8'h5A.
module tb_univ_shift_reg;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] SHL  = 3'b001;
    localparam logic [2:0] SHR  = 3'b010;
    localparam logic [2:0] ROL  = 3'b011;
    localparam logic [2:0] ROR  = 3'b100;
    localparam logic [2:0] LOAD = 3'b101;
    localparam logic [2:0] CLR  = 3'b110;
    localparam logic [2:0] ASR  = 3'b111;

    logic       clk;
    logic       rst, rst2;
    logic       en;
    logic [2:0] mode, mode2;
    logic       sin_l, sin_r;
    logic [7:0] d;
    logic [7:0] q, q2;
    logic       sout_l, sout_r, sout_l2, sout_r2;
    logic [3:0] bit_cnt, bit_cnt2;
    logic       drained, drained2;

    int n_checks = 0;
    int n_pass   = 0;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r), .d(d),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .bit_cnt(bit_cnt), .drained(drained)
    );

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) dut_rv (
        .clk(clk), .rst(rst2), .en(en), .mode(mode2), .sin_l(sin_l), .sin_r(sin_r), .d(d),
        .q(q2), .sout_l(sout_l2), .sout_r(sout_r2), .bit_cnt(bit_cnt2), .drained(drained2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] eq, input logic [3:0] ecnt);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".cnt"}, 32'(bit_cnt), 32'(ecnt));
        check({tag, ".drained"}, 32'(drained), 32'(ecnt == 4'd8));
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; mode = HOLD; mode2 = HOLD;
        sin_l = 1'b0; sin_r = 1'b0; d = 8'h00;
        #2;
        // Reset values on both instances
        check_state("reset", 8'h00, 4'd8);
        check("rv_reset.q", 32'(q2), 32'h5A);
        check("rv_reset.cnt", 32'(bit_cnt2), 32'd8);

        // Test 1: release reset, load A5
        step();
        rst = 1'b0; rst2 = 1'b0;
        en = 1'b1; mode = LOAD; d = 8'hA5;
        step();
        check_state("load_a5", 8'hA5, 4'd0);
        check("load_a5.sout_r", 32'(sout_r), 32'd1);

        // Test 2: serial drain via SHL
        pat = 8'hA5;
        mode = SHL; sin_l = 1'b0; d = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain.sout_l[%0d]", i), 32'(sout_l), 32'(pat[7 - i]));
            step();
            check($sformatf("drain.cnt[%0d]", i), 32'(bit_cnt), 32'(i + 1));
        end
        check_state("drained", 8'h00, 4'd8);
        step();
        check_state("drain_sat", 8'h00, 4'd8);

        // Test 3: rotate / ASR / SHR
        mode = LOAD; d = 8'h81; step();
        check_state("load_81", 8'h81, 4'd0);
        mode = ROL; sin_r = 1'b1; sin_l = 1'b0; step();
        check("rol.q", 32'(q), 32'h03);
        mode = ROR; sin_l = 1'b1; sin_r = 1'b0; step();
        check("ror.q", 32'(q), 32'h81);
        mode = ASR; sin_l = 1'b0; step();
        check("asr1.q", 32'(q), 32'hC0);
        step();
        check("asr2.q", 32'(q), 32'hE0);
        mode = SHR; sin_r = 1'b0; sin_l = 1'b1; step();
        check_state("shr0", 8'h70, 4'd5);
        sin_r = 1'b1; step();
        check_state("shr1", 8'hB8, 4'd6);

        // Test 4: enable low then HOLD
        mode = LOAD; d = 8'h3C; step();
        en = 1'b0; mode = SHL; sin_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("en0[%0d]", i), 8'h3C, 4'd0);
        end
        en = 1'b1; mode = HOLD;
        for (int i = 0; i < 2; i++) begin
            step();
            check_state($sformatf("hold[%0d]", i), 8'h3C, 4'd0);
        end
        mode = SHL; sin_l = 1'b1; step();
        check_state("shl1", 8'h79, 4'd1);

        // CLR ignores d
        mode = CLR; d = 8'hFF; step();
        check_state("clr", 8'h00, 4'd8);

        // Test 5: async reset between edges
        mode = LOAD; d = 8'hFF; step();
        mode = SHR; sin_r = 1'b0;
        repeat (3) step();
        check_state("shr3", 8'h1F, 4'd3);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 8'h00, 4'd8);
        rst = 1'b0;
        mode = SHL; sin_l = 1'b1; step();
        check_state("post_rst_shl", 8'h01, 4'd8);
        mode = LOAD; d = 8'h5A; step();
        check_state("post_rst_load", 8'h5A, 4'd0);

        // Test 6: RST_VAL instance held its reset value, then clears
        check("rv_hold.q", 32'(q2), 32'h5A);
        mode = HOLD; mode2 = CLR; step();
        check("rv_clr.q", 32'(q2), 32'h00);
        check("rv_clr.cnt", 32'(bit_cnt2), 32'd8);
        check("rv_clr.drained", 32'(drained2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
